switch_debouncer: RTL and testbench

//  Input-side counterpart of the switch-to-LED path. Turns raw, asynchronous,

---
 rtl/ctrl_pkg.sv | 14 +
 rtl/debounce_bit.sv | 86 ++++++++
 rtl/switch_debouncer.sv | 45 ++++
 tb/tb_switch_debouncer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-path constants and types for the board switch inputs.
// Both the debouncer top and its per-bit sub-module import this package.
package ctrl_pkg;

   localparam int N_SW_DEFAULT        = 3;
   localparam int DEBOUNCE_10MS_50MHZ = 500000;

   // Per-bit debounce state. It is decoded from (sw_q2, stable); it is not stored.
   typedef enum logic {
      DB_IDLE  = 1'b0,
      DB_CHECK = 1'b1
   } db_state_e;

endpackage : ctrl_pkg

// File: rtl/debounce_bit.sv
// Single-bit debouncer: a 2-flop synchroniser, a stability counter, the accepted
// level, and registered rise/fall pulses.
module debounce_bit
   import ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic event_o
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sw_q1;
   logic             sw_q2;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             accept;
   db_state_e        state;

   assign state  = (sw_q2 == stable_q) ? DB_IDLE : DB_CHECK;
   assign accept = (state == DB_CHECK) && (cnt_q == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values that existed before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_q1    <= 1'b0;
         sw_q2    <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         sw_q1    <= sw_i;
         sw_q2    <= sw_q1;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   // NOTE: each combinational output gets a default first. This prevents a
   // latch when a branch leaves the output unassigned.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      unique case (state)
         DB_IDLE: cnt_d = '0;
         DB_CHECK: begin
            if (accept) begin
               stable_d = sw_q2;
               cnt_d    = '0;
            end else begin
               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         default: cnt_d = '0;
      endcase
   end

   // Pulses are the next-state values of the pulse flops, so they line up with stable_q.
   always_comb begin
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (accept) begin
         rise_d = sw_q2;
         fall_d = ~sw_q2;
      end
   end

   assign level_o = stable_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign event_o = rise_d | fall_d;

endmodule : debounce_bit

// File: rtl/switch_debouncer.sv
// Debounces N_SW raw switch pins into clean levels and one-cycle edge pulses.
// It also produces a registered any-change pulse that lines up with the per-bit pulses.
module switch_debouncer
   import ctrl_pkg::*;
#(
   parameter int N_SW            = N_SW_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_SW-1:0] switch,
   output logic [N_SW-1:0] sw_level,
   output logic [N_SW-1:0] sw_rise,
   output logic [N_SW-1:0] sw_fall,
   output logic            sw_changed
);

   logic [N_SW-1:0] bit_event;
   logic            changed_q, changed_d;

   for (genvar i = 0; i < N_SW; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce_bit (
         .clk     (clk),
         .rst_n   (rst_n),
         .sw_i    (switch[i]),
         .level_o (sw_level[i]),
         .rise_o  (sw_rise[i]),
         .fall_o  (sw_fall[i]),
         .event_o (bit_event[i])
      );
   end

   // OR of the next-state pulses, so this pulse is set on the same edge as sw_rise/sw_fall.
   assign changed_d = |bit_event;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) changed_q <= 1'b0;
      else        changed_q <= changed_d;
   end

   assign sw_changed = changed_q;

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with N_SW=3 and DEBOUNCE_CYCLES=4.
// Every expected value below is derived by hand from the debounce timing.
module tb_switch_debouncer;

   localparam int N_SW = 3;
   localparam int DB   = 4;
   localparam int FIRE = DB + 2;   // edge that updates sw_level, counting the first sampling edge

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N_SW-1:0] switch = '0;
   logic [N_SW-1:0] sw_level, sw_rise, sw_fall;
   logic            sw_changed;

   int n_checks = 0;
   int n_fail   = 0;

   switch_debouncer #(
      .N_SW            (N_SW),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .switch     (switch),
      .sw_level   (sw_level),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .sw_changed (sw_changed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_quiet(input string tag, input logic [N_SW-1:0] lvl);
      check({tag, " level"},   32'(sw_level), 32'(lvl));
      check({tag, " rise"},    32'(sw_rise),  32'd0);
      check({tag, " fall"},    32'(sw_fall),  32'd0);
      check({tag, " changed"}, 32'(sw_changed), 32'd0);
   endtask

   // Step n_edges clock edges. The event must appear exactly on edge fire_edge and nowhere else.
   task automatic expect_event(input string tag, input logic [N_SW-1:0] old_lvl,
                               input logic [N_SW-1:0] new_lvl, input int n_edges,
                               input int fire_edge, input logic [N_SW-1:0] rise,
                               input logic [N_SW-1:0] fall);
      for (int e = 1; e <= n_edges; e++) begin
         step();
         if (e < fire_edge) begin
            expect_quiet($sformatf("%s e%0d", tag, e), old_lvl);
         end else if (e == fire_edge) begin
            check($sformatf("%s e%0d level", tag, e),   32'(sw_level), 32'(new_lvl));
            check($sformatf("%s e%0d rise", tag, e),    32'(sw_rise),  32'(rise));
            check($sformatf("%s e%0d fall", tag, e),    32'(sw_fall),  32'(fall));
            check($sformatf("%s e%0d changed", tag, e), 32'(sw_changed), 32'd1);
         end else begin
            expect_quiet($sformatf("%s e%0d", tag, e), new_lvl);
         end
      end
   endtask

   initial begin
      // 1) reset, then 20 idle cycles with all switches low
      repeat (3) step();
      expect_quiet("reset", 3'b000);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) expect_event("idle", 3'b000, 3'b000, 1, 99, 3'b000, 3'b000);

      // 3) a 3-cycle glitch on switch[1] is shorter than the threshold
      switch = 3'b010;
      repeat (3) step();
      switch = 3'b000;
      expect_event("glitch", 3'b000, 3'b000, 12, 99, 3'b000, 3'b000);

      // 2) a clean rise on switch[0] is accepted on the 6th edge
      switch = 3'b001;
      expect_event("rise0", 3'b000, 3'b001, 10, FIRE, 3'b001, 3'b000);

      // 4) two rises and one fall are accepted on the same edge
      switch = 3'b110;
      expect_event("multi", 3'b001, 3'b110, 10, FIRE, 3'b110, 3'b001);

      // return all bits low, so the toggle test starts from level 0 on bit 2
      switch = 3'b000;
      expect_event("clear", 3'b110, 3'b000, 10, FIRE, 3'b000, 3'b110);

      // 5) switch[2] toggles every cycle, ending high on the 50th cycle
      for (int i = 0; i < 49; i++) begin
         switch = {i[0], 2'b00};
         step();
         expect_quiet($sformatf("toggle c%0d", i), 3'b000);
      end
      switch = 3'b100;
      expect_event("toggle end", 3'b000, 3'b100, 10, FIRE, 3'b100, 3'b000);

      // 6) reset while bits 0 and 1 are counting (cnt reaches 2 after the 4th edge)
      switch = 3'b111;
      expect_event("precount", 3'b100, 3'b100, 4, 99, 3'b000, 3'b000);
      #2 rst_n = 1'b0;
      #1 expect_quiet("async reset", 3'b000);
      repeat (2) step();
      expect_quiet("held reset", 3'b000);
      #2 rst_n = 1'b1;
      expect_event("post reset", 3'b000, 3'b111, 10, FIRE, 3'b111, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_switch_debouncer
